// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b type definitions used by the data-memory responder and its
// neighbours.
//   lc3b_word       : 16-bit machine word (addresses, data)
//   lc3b_mem_wmask  : 2-bit byte-lane mask {hi, lo}
//   normalize_wmask : maps the "no lanes" encoding 2'b00 onto a full word
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_mem_wmask WMASK_WORD = 2'b11;

    // A requester that leaves both lanes clear means a full-word access.
    function automatic lc3b_mem_wmask normalize_wmask(input lc3b_mem_wmask mask);
        return (mask == 2'b00) ? WMASK_WORD : mask;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the MEM/WB-side request handshake and the physical memory port of
// the data-memory responder.
//   Requester side : data_request, load_mar, load_mdr, mem_read, mem_write,
//                    mem_byte_enable, mar_in, mdr_in -> data_response,
//                    mem_rdata, busy, error
//   Memory side    : pmem_address, pmem_wdata, pmem_byte_enable, pmem_read,
//                    pmem_write -> pmem_resp, pmem_rdata
// Modports:
//   slave  : the responder itself
//   master : whoever drives requests and models memory (stage + memory)
// -----------------------------------------------------------------------------
interface dmem_responder_if;

    logic                      data_request;
    logic                      load_mar;
    logic                      load_mdr;
    logic                      mem_read;
    logic                      mem_write;
    lc3b_types::lc3b_mem_wmask mem_byte_enable;
    lc3b_types::lc3b_word      mar_in;
    lc3b_types::lc3b_word      mdr_in;
    logic                      data_response;
    lc3b_types::lc3b_word      mem_rdata;
    logic                      busy;
    logic                      error;

    lc3b_types::lc3b_word      pmem_address;
    lc3b_types::lc3b_word      pmem_wdata;
    lc3b_types::lc3b_mem_wmask pmem_byte_enable;
    logic                      pmem_read;
    logic                      pmem_write;
    logic                      pmem_resp;
    lc3b_types::lc3b_word      pmem_rdata;

    modport slave (
        input  data_request, load_mar, load_mdr, mem_read, mem_write,
               mem_byte_enable, mar_in, mdr_in, pmem_resp, pmem_rdata,
        output data_response, mem_rdata, busy, error,
               pmem_address, pmem_wdata, pmem_byte_enable, pmem_read, pmem_write
    );

    modport master (
        output data_request, load_mar, load_mdr, mem_read, mem_write,
               mem_byte_enable, mar_in, mdr_in, pmem_resp, pmem_rdata,
        input  data_response, mem_rdata, busy, error,
               pmem_address, pmem_wdata, pmem_byte_enable, pmem_read, pmem_write
    );

endinterface

// File: rtl/dmem_lane_steer.sv
// -----------------------------------------------------------------------------
// dmem_lane_steer
// Combinational byte-lane steering between the MDR and the 16-bit memory bus.
//   wmask         in  : normalized lane mask (2'b11 word, 2'b10 hi, 2'b01 lo)
//   mdr           in  : current MDR contents (store data)
//   rdata         in  : raw word returned by memory
//   wdata_steered out : store word; byte stores replicate MDR[7:0] to both lanes
//   rdata_steered out : load word; byte loads return the selected byte
//                       zero-extended
// -----------------------------------------------------------------------------
module dmem_lane_steer
    import lc3b_types::*;
(
    input  lc3b_mem_wmask wmask,
    input  lc3b_word      mdr,
    input  lc3b_word      rdata,
    output lc3b_word      wdata_steered,
    output lc3b_word      rdata_steered
);

    logic       word_access;
    logic [7:0] rd_byte;

    assign word_access = (wmask == WMASK_WORD);

    // Each write lane carries its own MDR byte for words, else the low byte,
    // so the byte-enable alone decides which lane memory actually updates.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wlane
            assign wdata_steered[gi*8 +: 8] = word_access ? mdr[gi*8 +: 8] : mdr[7:0];
        end
    endgenerate

    // Only an explicit hi-lane-only mask picks the upper byte.
    assign rd_byte       = (wmask == 2'b10) ? rdata[15:8] : rdata[7:0];
    assign rdata_steered = word_access ? rdata : {8'h00, rd_byte};

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the MEM/WB data handshake. Owns MAR and MDR, runs
// one access on the physical memory port per request and answers with a
// single-cycle data_response; read data is returned through MDR (mem_rdata).
//
// Ports:
//   clk    in : system clock
//   reset  in : synchronous, active-high reset
//   bus       : dmem_responder_if.slave (request handshake + pmem port)
//
// Parameters:
//   TIMEOUT_CYCLES : ACCESS cycles allowed before an access is abandoned
//                    (only meaningful when DMEM_TIMEOUT_EN is defined)
//
// Build option:
//   DMEM_TIMEOUT_EN : when defined, an access that sees no pmem_resp within
//                     TIMEOUT_CYCLES ACCESS cycles completes with error=1
//                     (reads return 16'h0000). When undefined, ACCESS waits
//                     indefinitely and error is constantly 0.
// -----------------------------------------------------------------------------
module dmem_responder
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t        state_reg;
    lc3b_word      mar_reg;
    lc3b_word      mdr_reg;
    logic          op_write_reg;
    lc3b_mem_wmask wmask_reg;
    logic          data_response_reg;
    logic          busy_reg;
    logic          pmem_read_reg;
    logic          pmem_write_reg;
    logic          error_reg;

    lc3b_word      wdata_steered;
    lc3b_word      rdata_steered;
    logic          timeout_hit;

    dmem_lane_steer u_lane_steer (
        .wmask         (wmask_reg),
        .mdr           (mdr_reg),
        .rdata         (bus.pmem_rdata),
        .wdata_steered (wdata_steered),
        .rdata_steered (rdata_steered)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt_reg;

    // The counter reads k-1 during the k-th ACCESS cycle, so this fires in the
    // last allowed cycle; a pmem_resp in that same cycle still wins.
    assign timeout_hit = (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;

    // Keeps the parameter referenced in builds without the timeout.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            mar_reg           <= '0;
            mdr_reg           <= '0;
            op_write_reg      <= 1'b0;
            wmask_reg         <= '0;
            data_response_reg <= 1'b0;
            busy_reg          <= 1'b0;
            pmem_read_reg     <= 1'b0;
            pmem_write_reg    <= 1'b0;
            error_reg         <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            timeout_cnt_reg   <= '0;
`endif
        end else begin
            data_response_reg <= 1'b0;
            error_reg         <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Register loads are accepted only here, which keeps the
                    // address and store data of an in-flight access stable.
                    if (bus.load_mar) begin
                        mar_reg <= bus.mar_in;
                    end
                    if (bus.load_mdr) begin
                        mdr_reg <= bus.mdr_in;
                    end
                    if (bus.data_request) begin
                        wmask_reg <= normalize_wmask(bus.mem_byte_enable);
                        busy_reg  <= 1'b1;
                        if (bus.mem_read || bus.mem_write) begin
                            state_reg      <= ACCESS;
                            // Write has priority when both ops are requested.
                            op_write_reg   <= bus.mem_write;
                            pmem_write_reg <= bus.mem_write;
                            pmem_read_reg  <= !bus.mem_write;
`ifdef DMEM_TIMEOUT_EN
                            timeout_cnt_reg <= '0;
`endif
                        end else begin
                            state_reg         <= RESPOND;
                            data_response_reg <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
`ifdef DMEM_TIMEOUT_EN
                    timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
`endif
                    if (bus.pmem_resp) begin
                        state_reg         <= RESPOND;
                        pmem_read_reg     <= 1'b0;
                        pmem_write_reg    <= 1'b0;
                        data_response_reg <= 1'b1;
                        if (!op_write_reg) begin
                            mdr_reg <= rdata_steered;
                        end
                    end else if (timeout_hit) begin
                        state_reg         <= RESPOND;
                        pmem_read_reg     <= 1'b0;
                        pmem_write_reg    <= 1'b0;
                        data_response_reg <= 1'b1;
                        error_reg         <= 1'b1;
                        if (!op_write_reg) begin
                            mdr_reg <= '0;
                        end
                    end
                end

                RESPOND: begin
                    // The requester releases data_request on this same edge,
                    // so the next IDLE cycle only ever sees a fresh request.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    pmem_read_reg  <= 1'b0;
                    pmem_write_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_response    = data_response_reg;
    assign bus.mem_rdata        = mdr_reg;
    assign bus.busy             = busy_reg;
    assign bus.error            = error_reg;
    assign bus.pmem_address     = mar_reg & ~16'h0001;
    assign bus.pmem_wdata       = wdata_steered;
    assign bus.pmem_byte_enable = wmask_reg;
    assign bus.pmem_read        = pmem_read_reg;
    assign bus.pmem_write       = pmem_write_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Drives requests and models physical memory through dmem_responder_if.
// Expected values come from a transaction-level reference (lane rules written
// as byte arithmetic and a single model MDR value). Define DMEM_TIMEOUT_EN to
// build the DUT with TIMEOUT_CYCLES=8 and run the timeout scenarios.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

`ifdef DMEM_TIMEOUT_EN
    dmem_responder #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`else
    dmem_responder u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] model_mdr;

    // Observations gathered by do_access for the scenario tasks to judge.
    int          obs_strobes;
    int          obs_latency;
    int          obs_pulses;
    logic        obs_rd;
    logic        obs_wr;
    logic        obs_addr_stable;
    logic        obs_error;
    logic        obs_busy_after;
    logic [15:0] obs_addr;
    logic [15:0] obs_wdata;
    logic [15:0] obs_rdata;
    logic [1:0]  obs_be;

    // ---------------- reference rules ----------------
    function automatic logic [1:0] ref_lanes(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

    function automatic logic [15:0] ref_store_word(input logic [15:0] d, input logic [1:0] be);
        int b;
        if (ref_lanes(be) == 2'b11) return d;
        b = int'(d) % 256;
        return 16'(b * 257);
    endfunction

    function automatic logic [15:0] ref_load_word(input logic [15:0] r, input logic [1:0] be);
        case (ref_lanes(be))
            2'b11:   return r;
            2'b10:   return 16'(int'(r) / 256);
            default: return 16'(int'(r) % 256);
        endcase
    endfunction

    // ---------------- transaction driver ----------------
    // Starts just after a negedge; returns just after the negedge of the
    // IDLE cycle that follows the response. resp_after=0 means memory never
    // answers.
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] data, input logic [1:0] be,
                             input logic ld_mar, input logic ld_mdr, input int resp_after,
                             input logic [15:0] rdata, input logic poke);
        bus.mar_in          = addr;
        bus.mdr_in          = data;
        bus.load_mar        = ld_mar;
        bus.load_mdr        = ld_mdr;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.data_request    = 1'b1;
        bus.pmem_resp       = 1'b0;
        obs_strobes = 0; obs_latency = -1; obs_pulses = 0; obs_addr_stable = 1'b1;
        obs_rd = 1'b0; obs_wr = 1'b0; obs_error = 1'b0; obs_busy_after = 1'b1;
        obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_be = '0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 40 && obs_latency < 0; cyc++) begin
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = 16'($urandom);
            bus.load_mar   = 1'b0;
            bus.load_mdr   = 1'b0;
            if (bus.data_response) begin
                obs_latency = cyc;
                obs_pulses++;
                obs_rdata = bus.mem_rdata;
                obs_error = bus.error;
                bus.data_request = 1'b0;
                bus.mem_read     = 1'b0;
                bus.mem_write    = 1'b0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                obs_strobes++;
                if (obs_strobes == 1) begin
                    obs_rd = bus.pmem_read; obs_wr = bus.pmem_write;
                    obs_addr = bus.pmem_address; obs_wdata = bus.pmem_wdata;
                    obs_be = bus.pmem_byte_enable;
                    if (poke) begin
                        bus.load_mar = 1'b1; bus.mar_in = 16'hFFFF;
                        bus.load_mdr = 1'b1; bus.mdr_in = ~data;
                    end
                end else if (bus.pmem_address !== obs_addr) begin
                    obs_addr_stable = 1'b0;
                end
                if (obs_strobes == resp_after) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = rdata;
                end
            end
            @(negedge clk);
        end
        bus.pmem_resp = 1'b0;
        bus.load_mar  = 1'b0;
        bus.load_mdr  = 1'b0;
        if (obs_latency < 0) begin
            // No response: recover the DUT so later scenarios still run.
            bus.data_request = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_mdr = '0;
        end else begin
            obs_busy_after = bus.busy;
            if (bus.data_response) obs_pulses++;
        end
        $display("txn rd=%0b wr=%0b addr=%h be=%b strobes=%0d lat=%0d rdata=%h err=%0b",
                 rd, wr, addr, be, obs_strobes, obs_latency, obs_rdata, obs_error);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.data_request = 0; bus.load_mar = 0; bus.load_mdr = 0; bus.mem_read = 0;
        bus.mem_write = 0; bus.mem_byte_enable = 0; bus.mar_in = 0; bus.mdr_in = 0;
        bus.pmem_resp = 0; bus.pmem_rdata = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.data_response, bus.busy, bus.error, bus.pmem_read, bus.pmem_write} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000",
                            {bus.data_response, bus.busy, bus.error, bus.pmem_read, bus.pmem_write});
        end
        total++;
        if ({bus.mem_rdata, bus.pmem_address, bus.pmem_wdata, bus.pmem_byte_enable} !== 50'b0) begin
            bad++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h be=%b want all 0",
                            bus.mem_rdata, bus.pmem_address, bus.pmem_wdata, bus.pmem_byte_enable);
        end
        reset = 1'b0;
        model_mdr = '0;
        @(negedge clk);
    endtask

    task automatic test_word_read();
        do_access(1'b1, 1'b0, 16'h3002, 16'h0000, 2'b11, 1'b1, 1'b0, 3, 16'hBEEF, 1'b0);
        model_mdr = 16'hBEEF;
        total++; if (obs_strobes !== 3) begin bad++; $display("FAIL word_read strobes: got %0d want 3", obs_strobes); end
        total++; if ({obs_rd, obs_wr} !== 2'b10) begin bad++; $display("FAIL word_read op: got %b want 10", {obs_rd, obs_wr}); end
        total++; if (obs_addr !== 16'h3002) begin bad++; $display("FAIL word_read addr: got %h want 3002", obs_addr); end
        total++; if (obs_latency !== 4) begin bad++; $display("FAIL word_read latency: got %0d want 4", obs_latency); end
        total++; if (obs_pulses !== 1) begin bad++; $display("FAIL word_read pulses: got %0d want 1", obs_pulses); end
        total++; if (obs_rdata !== 16'hBEEF) begin bad++; $display("FAIL word_read rdata: got %h want beef", obs_rdata); end
        total++; if (obs_error !== 1'b0) begin bad++; $display("FAIL word_read error: got %b want 0", obs_error); end
        total++; if (obs_busy_after !== 1'b0) begin bad++; $display("FAIL word_read busy_after: got %b want 0", obs_busy_after); end
    endtask

    task automatic test_byte_store();
        do_access(1'b0, 1'b1, 16'h4001, 16'h12A5, 2'b10, 1'b1, 1'b1, 1, 16'h0000, 1'b0);
        model_mdr = 16'h12A5;
        total++; if (obs_wdata !== 16'hA5A5) begin bad++; $display("FAIL byte_store wdata: got %h want a5a5", obs_wdata); end
        total++; if (obs_be !== 2'b10) begin bad++; $display("FAIL byte_store be: got %b want 10", obs_be); end
        total++; if (obs_addr !== 16'h4000) begin bad++; $display("FAIL byte_store addr: got %h want 4000", obs_addr); end
        total++; if ({obs_rd, obs_wr} !== 2'b01) begin bad++; $display("FAIL byte_store op: got %b want 01", {obs_rd, obs_wr}); end
        total++; if (obs_latency !== 2) begin bad++; $display("FAIL byte_store latency: got %0d want 2", obs_latency); end
        total++; if (obs_rdata !== 16'h12A5) begin bad++; $display("FAIL byte_store mem_rdata: got %h want 12a5", obs_rdata); end
    endtask

    task automatic test_byte_read();
        do_access(1'b1, 1'b0, 16'h5004, 16'h0000, 2'b01, 1'b1, 1'b0, 2, 16'h7F80, 1'b0);
        total++; if (obs_rdata !== 16'h0080) begin bad++; $display("FAIL byte_read_lo rdata: got %h want 0080", obs_rdata); end
        do_access(1'b1, 1'b0, 16'h5005, 16'h0000, 2'b10, 1'b1, 1'b0, 2, 16'h7F80, 1'b0);
        total++; if (obs_rdata !== 16'h007F) begin bad++; $display("FAIL byte_read_hi rdata: got %h want 007f", obs_rdata); end
        do_access(1'b1, 1'b0, 16'h5006, 16'h0000, 2'b00, 1'b1, 1'b0, 1, 16'h7F80, 1'b0);
        model_mdr = 16'h7F80;
        total++; if (obs_be !== 2'b11) begin bad++; $display("FAIL byte_read_be00 be: got %b want 11", obs_be); end
        total++; if (obs_rdata !== 16'h7F80) begin bad++; $display("FAIL byte_read_be00 rdata: got %h want 7f80", obs_rdata); end
    endtask

    task automatic test_zero_op();
        do_access(1'b0, 1'b0, 16'h6000, 16'h5A5A, 2'b11, 1'b1, 1'b1, 1, 16'h0000, 1'b0);
        model_mdr = 16'h5A5A;
        total++; if (obs_latency !== 1) begin bad++; $display("FAIL zero_op latency: got %0d want 1", obs_latency); end
        total++; if (obs_strobes !== 0) begin bad++; $display("FAIL zero_op strobes: got %0d want 0", obs_strobes); end
        total++; if (obs_rdata !== 16'h5A5A) begin bad++; $display("FAIL zero_op mem_rdata: got %h want 5a5a", obs_rdata); end
        total++; if (obs_pulses !== 1) begin bad++; $display("FAIL zero_op pulses: got %0d want 1", obs_pulses); end
    endtask

    task automatic test_load_protect();
        do_access(1'b1, 1'b0, 16'h2468, 16'h0F0F, 2'b11, 1'b1, 1'b1, 3, 16'h1357, 1'b1);
        model_mdr = 16'h1357;
        total++; if (obs_addr_stable !== 1'b1) begin bad++; $display("FAIL load_protect addr_stable: got %b want 1", obs_addr_stable); end
        total++; if (obs_rdata !== 16'h1357) begin bad++; $display("FAIL load_protect rdata: got %h want 1357", obs_rdata); end
        total++; if (bus.pmem_address !== 16'h2468) begin bad++; $display("FAIL load_protect mar: got %h want 2468", bus.pmem_address); end
    endtask

    task automatic test_back_to_back();
        // Both ops requested: the write wins, MDR stays as loaded.
        do_access(1'b1, 1'b1, 16'h7000, 16'hC001, 2'b11, 1'b1, 1'b1, 1, 16'hDEAD, 1'b0);
        model_mdr = 16'hC001;
        total++; if ({obs_rd, obs_wr} !== 2'b01) begin bad++; $display("FAIL b2b_write_wins op: got %b want 01", {obs_rd, obs_wr}); end
        total++; if (obs_wdata !== 16'hC001) begin bad++; $display("FAIL b2b_write_wins wdata: got %h want c001", obs_wdata); end
        total++; if (obs_rdata !== 16'hC001) begin bad++; $display("FAIL b2b_write_wins mem_rdata: got %h want c001", obs_rdata); end
        // Issued in the very next IDLE cycle.
        do_access(1'b1, 1'b0, 16'h7002, 16'h0000, 2'b11, 1'b1, 1'b0, 1, 16'h4242, 1'b0);
        model_mdr = 16'h4242;
        total++; if (obs_latency !== 2) begin bad++; $display("FAIL b2b_second latency: got %0d want 2", obs_latency); end
        total++; if (obs_rdata !== 16'h4242) begin bad++; $display("FAIL b2b_second rdata: got %h want 4242", obs_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        pulses = 0;
        bus.mar_in = 16'h1234; bus.load_mar = 1'b1; bus.mem_read = 1'b1;
        bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b11; bus.data_request = 1'b1;
        @(negedge clk);
        bus.load_mar = 1'b0;
        total++; if (bus.pmem_read !== 1'b1) begin bad++; $display("FAIL rst_mid strobe_before: got %b want 1", bus.pmem_read); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({bus.busy, bus.pmem_read, bus.data_response} !== 3'b000) begin
            bad++; $display("FAIL rst_mid after_reset: got busy/rd/resp=%b want 000",
                            {bus.busy, bus.pmem_read, bus.data_response});
        end
        reset = 1'b0; bus.data_request = 1'b0; bus.mem_read = 1'b0;
        model_mdr = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.data_response) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid stray_response: got %0d want 0", pulses); end
        total++; if (bus.mem_rdata !== model_mdr) begin bad++; $display("FAIL rst_mid mem_rdata: got %h want %h", bus.mem_rdata, model_mdr); end
    endtask

    task automatic test_random();
        logic        rd, wr, ld_mdr, is_op;
        logic [15:0] addr, data, rdata;
        logic [1:0]  be;
        int          wt;
        for (int t = 0; t < 24; t++) begin
            rd = 1'($urandom); wr = 1'($urandom); ld_mdr = 1'($urandom);
            addr = 16'($urandom); data = 16'($urandom); rdata = 16'($urandom);
            be = 2'($urandom); wt = int'($urandom_range(1, 4));
            is_op = rd | wr;
            if (ld_mdr) model_mdr = data;
            do_access(rd, wr, addr, data, be, 1'b1, ld_mdr, wt, rdata, 1'b0);
            total++; if (obs_latency !== (is_op ? wt + 1 : 1)) begin
                bad++; $display("FAIL rand%0d latency: got %0d want %0d", t, obs_latency, is_op ? wt + 1 : 1);
            end
            total++; if (obs_strobes !== (is_op ? wt : 0)) begin
                bad++; $display("FAIL rand%0d strobes: got %0d want %0d", t, obs_strobes, is_op ? wt : 0);
            end
            if (is_op) begin
                total++; if ({obs_rd, obs_wr, obs_addr, obs_be} !== {!wr, wr, addr & 16'hFFFE, ref_lanes(be)}) begin
                    bad++; $display("FAIL rand%0d bus: got rd=%b wr=%b addr=%h be=%b want rd=%b wr=%b addr=%h be=%b",
                                    t, obs_rd, obs_wr, obs_addr, obs_be, !wr, wr, addr & 16'hFFFE, ref_lanes(be));
                end
                if (wr) begin
                    total++; if (obs_wdata !== ref_store_word(model_mdr, be)) begin
                        bad++; $display("FAIL rand%0d wdata: got %h want %h", t, obs_wdata, ref_store_word(model_mdr, be));
                    end
                end else begin
                    model_mdr = ref_load_word(rdata, be);
                end
            end
            total++; if (obs_rdata !== model_mdr) begin
                bad++; $display("FAIL rand%0d mem_rdata: got %h want %h", t, obs_rdata, model_mdr);
            end
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access(1'b1, 1'b0, 16'h5000, 16'h1111, 2'b11, 1'b1, 1'b1, 0, 16'hAAAA, 1'b0);
        model_mdr = 16'h0000;
        total++; if (obs_strobes !== 8) begin bad++; $display("FAIL timeout strobes: got %0d want 8", obs_strobes); end
        total++; if (obs_latency !== 9) begin bad++; $display("FAIL timeout latency: got %0d want 9", obs_latency); end
        total++; if (obs_error !== 1'b1) begin bad++; $display("FAIL timeout error: got %b want 1", obs_error); end
        total++; if (obs_rdata !== 16'h0000) begin bad++; $display("FAIL timeout rdata: got %h want 0000", obs_rdata); end
        // Response in the expiry cycle completes normally.
        do_access(1'b1, 1'b0, 16'h5002, 16'h0000, 2'b11, 1'b1, 1'b0, 8, 16'hC3C3, 1'b0);
        model_mdr = 16'hC3C3;
        total++; if (obs_error !== 1'b0) begin bad++; $display("FAIL timeout_edge error: got %b want 0", obs_error); end
        total++; if (obs_rdata !== 16'hC3C3) begin bad++; $display("FAIL timeout_edge rdata: got %h want c3c3", obs_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_word_read();
        test_byte_store();
        test_byte_read();
        test_zero_op();
        test_load_protect();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
